// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_t;

    // Wraps explicitly so NUM_REQ need not be a power of two.
    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin search: first valid requester at or after rr_ptr, wrapping.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               found,
    output logic [ID_W-1:0]    winner
);

    logic [NUM_REQ-1:0] masked;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        masked = '0;
        winner = '0;
        found  = |req_valid;
        for (int i = 0; i < NUM_REQ; i++) begin
            masked[i] = req_valid[i] && (i >= int'(rr_ptr));
        end
        // Descending scan so the lowest index is the last one written.
        if (|masked) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (masked[i]) winner = ID_W'(i);
            end
        end else begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (req_valid[i]) winner = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready requesters.
// Define FIFO_ARB_BURST_EN to let an owner hold the grant for up to MAX_BURST beats.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int  NUM_REQ    = 4,
    parameter int  DATA_WIDTH = 8,
    parameter int  MAX_BURST  = 4,
    localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          wr_en,
    output logic [DATA_WIDTH-1:0]         data_wr,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy
);

    if (NUM_REQ < 2 || NUM_REQ > 16 || MAX_BURST < 1 || MAX_BURST > 255) begin : g_param_check
        $error("fifo_wr_arbiter: parameter out of range");
    end

    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic            pick_found;
    logic [ID_W-1:0] pick_id;
    logic            win_valid;
    logic [ID_W-1:0] win_id;
    logic            xfer;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_picker (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .found     (pick_found),
        .winner    (pick_id)
    );

`ifdef FIFO_ARB_BURST_EN
    localparam int BEATS_W = $clog2(MAX_BURST + 1);

    arb_state_t         state_q, state_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic [BEATS_W-1:0] beats_q, beats_d;
`endif

    always_comb begin
        win_id    = pick_id;
        win_valid = pick_found;
`ifdef FIFO_ARB_BURST_EN
        // The owner keeps the grant even if its valid drops; that cycle simply ends the burst.
        if (state_q == ARB_HOLD) begin
            win_id    = owner_q;
            win_valid = 1'b1;
        end
`endif
        xfer      = win_valid && req_valid[win_id] && !fifo_full && !rst;
        wr_en     = xfer;
        req_ready = '0;
        grant_id  = '0;
        data_wr   = '0;
        if (!rst) begin
            if (win_valid && !fifo_full) req_ready[win_id] = 1'b1;
            grant_id = win_id;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (ID_W'(k) == win_id) data_wr = req_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef FIFO_ARB_BURST_EN
    assign busy = !rst && (state_q == ARB_HOLD);

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        beats_d  = beats_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ARB_IDLE: begin
                if (xfer) begin
                    if (MAX_BURST > 1) begin
                        state_d = ARB_HOLD;
                        owner_d = win_id;
                        beats_d = BEATS_W'(1);
                    end else begin
                        rr_ptr_d = ID_W'(rr_next(int'(win_id), NUM_REQ));
                    end
                end
            end
            ARB_HOLD: begin
                if (!req_valid[owner_q] || (xfer && beats_q == BEATS_W'(MAX_BURST - 1))) begin
                    state_d  = ARB_IDLE;
                    beats_d  = '0;
                    rr_ptr_d = ID_W'(rr_next(int'(owner_q), NUM_REQ));
                end else if (xfer) begin
                    beats_d = beats_q + BEATS_W'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            owner_q  <= '0;
            beats_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            beats_q  <= beats_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    assign busy = 1'b0;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer) rr_ptr_d = ID_W'(rr_next(int'(win_id), NUM_REQ));
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter driving a depth-12 FIFO model; honours FIFO_ARB_BURST_EN.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int MAX_BURST  = 4;
    localparam int ID_W       = 2;
    localparam int FIFO_DEPTH = 12;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          wr_en;
    logic [DATA_WIDTH-1:0]         data_wr;
    logic [ID_W-1:0]               grant_id;
    logic                          busy;

    fifo_wr_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_BURST  (MAX_BURST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_full (fifo_full),
        .wr_en     (wr_en),
        .data_wr   (data_wr),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ID_W-1:0]       id;
        logic [DATA_WIDTH-1:0] data;
        logic                  busy;
    } exp_t;

    exp_t                  exp_q[$];
    logic [DATA_WIDTH-1:0] fifo_q[$];
    int                    src_left[NUM_REQ];
    int                    src_next[NUM_REQ];
    bit                    auto_drain = 1'b1;
    bit                    rd_pulse   = 1'b0;
    int                    errors = 0;
    int                    checks = 0;

    task automatic drive_inputs();
        for (int k = 0; k < NUM_REQ; k++) begin
            req_valid[k] = (src_left[k] > 0);
            req_data[k*DATA_WIDTH +: DATA_WIDTH] = 8'(16 * k + src_next[k]);
        end
        fifo_full = (fifo_q.size() >= FIFO_DEPTH);
    endtask

    task automatic load(input int k, input int start, input int n);
        src_next[k] = start;
        src_left[k] = n;
    endtask

    task automatic push_exp(input int id, input int data, input bit bsy);
        exp_t e;
        e.id   = ID_W'(id);
        e.data = 8'(data);
        e.busy = bsy;
        exp_q.push_back(e);
    endtask

    // Expected order when every requester is valid with n/NUM_REQ beats each.
    task automatic push_all_valid(input int n);
        int id, beat;
        bit bsy;
        for (int i = 0; i < n; i++) begin
`ifdef FIFO_ARB_BURST_EN
            id   = (i / MAX_BURST) % NUM_REQ;
            beat = (i % MAX_BURST) + MAX_BURST * (i / (MAX_BURST * NUM_REQ));
            bsy  = (i % MAX_BURST) != 0;
`else
            id   = i % NUM_REQ;
            beat = i / NUM_REQ;
            bsy  = 1'b0;
`endif
            push_exp(id, 16 * id + beat, bsy);
        end
    endtask

    // One clock: monitor at negedge, advance sources and FIFO model just after posedge.
    task automatic tick();
        exp_t            e;
        bit              wrote;
        bit              do_rd;
        logic [ID_W-1:0] who;
        wrote = 1'b0;
        who   = '0;
        @(negedge clk);
        checks++;
        if ($countones(req_ready) > 1) begin
            errors++;
            $display("FAIL ready_onehot: req_ready=%b, required at most one bit", req_ready);
        end
        checks++;
        if (wr_en !== |(req_valid & req_ready)) begin
            errors++;
            $display("FAIL wr_en_handshake: wr_en=%b, required %b", wr_en, |(req_valid & req_ready));
        end
        if (fifo_full || rst) begin
            checks++;
            if (wr_en !== 1'b0 || req_ready !== '0) begin
                errors++;
                $display("FAIL blocked: wr_en=%b req_ready=%b, required 0 and 0000", wr_en, req_ready);
            end
        end
        if (wr_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: id=%0d data=%02h, required no write", grant_id, data_wr);
            end else begin
                e = exp_q.pop_front();
                if (grant_id !== e.id || data_wr !== e.data || busy !== e.busy) begin
                    errors++;
                    $display("FAIL write_order: id=%0d data=%02h busy=%b, required id=%0d data=%02h busy=%b",
                             grant_id, data_wr, busy, e.id, e.data, e.busy);
                end
            end
            checks++;
            if (req_ready !== (4'b0001 << grant_id)) begin
                errors++;
                $display("FAIL ready_match: req_ready=%b, required one-hot of id %0d", req_ready, grant_id);
            end
            fifo_q.push_back(data_wr);
            wrote = 1'b1;
            who   = grant_id;
        end
        do_rd = (auto_drain || rd_pulse) && (fifo_q.size() > 0);
        @(posedge clk);
        #1;
        if (wrote) begin
            src_left[who]--;
            src_next[who]++;
        end
        if (do_rd) void'(fifo_q.pop_front());
        rd_pulse = 1'b0;
        drive_inputs();
    endtask

    task automatic run_until_empty(input string name, input int budget, output int n);
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d writes outstanding after %0d cycles, required 0", name, exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drive_inputs();
        tick();
        rst = 1'b0;
        drive_inputs();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < NUM_REQ; k++) load(k, 0, 1);
        drive_inputs();
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b, required 0", wr_en); end
            checks++;
            if (req_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b, required 0000", req_ready); end
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
            checks++;
            if (grant_id !== '0) begin errors++; $display("FAIL reset_grant_id: got %0d, required 0", grant_id); end
            checks++;
            if (data_wr !== '0) begin errors++; $display("FAIL reset_data_wr: got %02h, required 00", data_wr); end
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < NUM_REQ; k++) src_left[k] = 0;
        rst = 1'b0;
        drive_inputs();
        repeat (2) tick();
    endtask

    task automatic test_round_robin();
        int n;
        auto_drain = 1'b1;
        for (int k = 0; k < NUM_REQ; k++) load(k, 0, 4);
        drive_inputs();
        push_all_valid(16);
        run_until_empty("round_robin", 40, n);
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL round_robin_cycles: took %0d cycles, required 16", n);
        end
        repeat (2) tick();
    endtask

    task automatic test_early_end();
        int n;
        load(2, 0, 2);
        load(3, 0, 4);
        drive_inputs();
`ifdef FIFO_ARB_BURST_EN
        push_exp(2, 8'h20, 1'b0); push_exp(2, 8'h21, 1'b1);
        push_exp(3, 8'h30, 1'b0); push_exp(3, 8'h31, 1'b1);
        push_exp(3, 8'h32, 1'b1); push_exp(3, 8'h33, 1'b1);
`else
        push_exp(2, 8'h20, 1'b0); push_exp(3, 8'h30, 1'b0);
        push_exp(2, 8'h21, 1'b0); push_exp(3, 8'h31, 1'b0);
        push_exp(3, 8'h32, 1'b0); push_exp(3, 8'h33, 1'b0);
`endif
        run_until_empty("early_end", 30, n);
        checks++;
`ifdef FIFO_ARB_BURST_EN
        if (n != 7) begin errors++; $display("FAIL early_end_cycles: took %0d cycles, required 7", n); end
`else
        if (n != 6) begin errors++; $display("FAIL early_end_cycles: took %0d cycles, required 6", n); end
`endif
        repeat (2) tick();
    endtask

    task automatic test_full_backpressure();
        int n;
        auto_drain = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) load(k, 0, 4);
        drive_inputs();
        push_all_valid(16);
        n = 0;
        while (exp_q.size() > 4 && n < 30) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 4 || fifo_full !== 1'b1) begin
            errors++;
            $display("FAIL full_fill: outstanding=%0d full=%b, required 4 and 1", exp_q.size(), fifo_full);
        end
        repeat (4) tick();
        checks++;
        if (exp_q.size() != 4) begin
            errors++;
            $display("FAIL full_stall: outstanding=%0d, required 4", exp_q.size());
        end
        rd_pulse = 1'b1;
        tick();
        repeat (3) tick();
        checks++;
        if (exp_q.size() != 3) begin
            errors++;
            $display("FAIL full_one_write: outstanding=%0d, required 3", exp_q.size());
        end
        auto_drain = 1'b1;
        run_until_empty("full_drain", 30, n);
        repeat (3) tick();
    endtask

    task automatic test_reset_mid_burst();
        int n;
        load(1, 0, 4);
        drive_inputs();
        push_exp(1, 8'h10, 1'b0);
        run_until_empty("mid_burst_pre", 10, n);
        rst = 1'b1;
        drive_inputs();
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b0 || req_ready !== '0) begin
            errors++;
            $display("FAIL mid_burst_reset: wr_en=%b req_ready=%b, required 0 and 0000", wr_en, req_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        load(0, 0, 1);
        load(2, 0, 1);
        drive_inputs();
`ifdef FIFO_ARB_BURST_EN
        push_exp(0, 8'h00, 1'b0); push_exp(1, 8'h11, 1'b0); push_exp(1, 8'h12, 1'b1);
        push_exp(1, 8'h13, 1'b1); push_exp(2, 8'h20, 1'b0);
`else
        push_exp(0, 8'h00, 1'b0); push_exp(1, 8'h11, 1'b0); push_exp(2, 8'h20, 1'b0);
        push_exp(1, 8'h12, 1'b0); push_exp(1, 8'h13, 1'b0);
`endif
        run_until_empty("after_reset", 30, n);
        repeat (2) tick();
    endtask

    task automatic test_sparse();
        int n;
        apply_reset();
        load(3, 0, 1);
        drive_inputs();
        push_exp(3, 8'h30, 1'b0);
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sparse_immediate: outstanding=%0d after first cycle, required 0", exp_q.size());
        end
        run_until_empty("sparse", 5, n);
        repeat (2) tick();
        load(0, 0, 1);
        load(1, 0, 1);
        drive_inputs();
        push_exp(0, 8'h00, 1'b0);
        push_exp(1, 8'h10, 1'b0);
        run_until_empty("sparse_wrap", 10, n);
        repeat (2) tick();
    endtask

    initial begin
        for (int k = 0; k < NUM_REQ; k++) load(k, 0, 0);
        drive_inputs();
        test_reset();
        test_round_robin();
        test_early_end();
        test_full_backpressure();
        test_reset_mid_burst();
        test_sparse();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the write side of one `fifo` instance among `NUM_REQ` requesters on a single clock domain. Each requester presents data on a valid/ready handshake. The arbiter selects one requester per cycle and drives the FIFO's `wr_en`/`data_wr`, honouring `fifo_full`. It sits directly in front of the FIFO's write port; in an async FIFO instance, the FIFO's `wr_clk` is connected to this block's `clk`.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `DATA_WIDTH`, default 8: FIFO data width; must match the FIFO.
- `MAX_BURST`, default 4: maximum consecutive beats granted to one owner (burst mode only), 1..255.
- `clk`  in  1: single clock; drives the FIFO `wr_clk`.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  NUM_REQ: per-requester data valid.
- `req_data`  in  NUM_REQ*DATA_WIDTH: packed data; requester k occupies bits `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `req_ready`  out  NUM_REQ: per-requester accept; at most one bit set.
- `fifo_full`  in  1: from the FIFO.
- `wr_en`  out  1: to the FIFO.
- `data_wr`  out  DATA_WIDTH: to the FIFO.
- `grant_id`  out  ID_W = max(1, $clog2(NUM_REQ)): index of the current winner; valid when `wr_en` = 1.
- `busy`  out  1: 1 while in state HOLD.

## Operation
- **Transfer:** a transfer for requester k happens in a cycle where `req_valid[k] & req_ready[k]`. In that cycle `wr_en` = 1 and `data_wr` = k's data.
- **Full:** `req_ready[k]` = (k is the winner) & !`fifo_full`. `fifo_full` = 1 forces all `req_ready` and `wr_en` to 0. No data is ever dropped or duplicated.
- **Round-robin pointer:** `rr_ptr` (ID_W bits, reset 0). The winner is the first requester with `req_valid` set, searching `rr_ptr`, `rr_ptr`+1, …, wrapping modulo NUM_REQ.
- **State IDLE:**
  - The winner is picked combinationally from current `req_valid`.
  - On a transfer without burst mode: `rr_ptr` ← (winner+1) mod NUM_REQ and the state stays IDLE.
  - On a transfer with burst mode and MAX_BURST > 1: the state goes to HOLD, with `owner` ← winner and `beats` ← 1.
  - With no valid requester, or with `fifo_full` = 1: no transfer and `rr_ptr` is unchanged.
- **State HOLD (burst mode only):**
  - The winner is `owner` unconditionally; other requesters see `req_ready` = 0.
  - Each transfer increments `beats`.
  - HOLD is left for IDLE at the clock edge where either of these holds:
    - `req_valid[owner]` = 0;
    - a transfer makes `beats` reach MAX_BURST.
  - On leaving, `rr_ptr` ← (owner+1) mod NUM_REQ.
  - `fifo_full` stalls the burst: the state stays HOLD and `beats` is unchanged.
- **Widths and wrap:**
  - `beats` is $clog2(MAX_BURST+1) bits and never exceeds MAX_BURST.
  - Pointer increment wraps explicitly at NUM_REQ, which need not be a power of two.
- **Requester protocol:** requesters must not drop `req_valid` or change `req_data` without a transfer. The arbiter does not check this. If it happens in HOLD, it simply ends the burst.

## Timing
- Zero-cycle latency: `wr_en`, `data_wr`, `req_ready` and `grant_id` are combinational from registered state (`state`, `rr_ptr`, `owner`, `beats`) plus `req_valid`, `req_data` and `fifo_full`.
- No combinational path from `req_ready` back to any input.
- **Reset values:**
  - `state` = IDLE, `rr_ptr` = 0, `owner` = 0, `beats` = 0.
  - Outputs forced during reset: `wr_en` = 0, `req_ready` = 0, `busy` = 0, `grant_id` = 0, `data_wr` = 0.
- Reset asserted mid-burst returns to IDLE on that edge. The beat in that cycle is not transferred, because `wr_en` is gated by `rst`.
- `fifo_full` is sampled in the same cycle as the write. The FIFO must drop `fifo_full` only when space exists, so one write per cycle at full throughput is legal.

## Configuration
- `FIFO_ARB_BURST_EN` defined:
  - The HOLD state and the `beats` counter are compiled in.
  - An owner keeps the grant for up to MAX_BURST consecutive beats.
- `FIFO_ARB_BURST_EN` undefined:
  - Only IDLE exists; re-arbitration happens after every transfer (strict per-beat round robin).
  - `busy` is tied to 0 and MAX_BURST is ignored.

## Structure
- **Package `fifo_arb_pkg`:**
  - `typedef enum logic [0:0] {ARB_IDLE, ARB_HOLD} arb_state_t`.
  - Function `rr_next(ptr, n)` returning (ptr+1) mod n.
- **Sub-module `rr_picker`:** combinational. Inputs `req_valid`, `rr_ptr`; outputs `found` and `winner` (ID_W). It implements a masked then unmasked first-one search.

## Test plan
Bench parameters: NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4, FIFO DEPTH=12, `clk` = FIFO `wr_clk`. Expected writes are modelled in a queue and compared against FIFO read-back.

- **Per-beat round robin (macro off):** all four valid continuously, data = 8'h10·k + beat. Expected: FIFO write order is k = 0,1,2,3,0,… and `req_ready` is one-hot every cycle.
- **Burst cap (macro on):** all valid. Expected: owner 0 gets exactly 4 beats, then owner 1 gets 4, with `busy` = 1 throughout each burst. `rr_ptr` wraps 3 → 0 after 16 writes.
- **Early burst end (macro on):** requester 2 drops `req_valid` after 2 beats. Expected: return to IDLE on that edge, and requester 3 wins the next cycle.
- **Full back-pressure:** fill the FIFO to 12 entries, keep all requesters valid. Expected: `wr_en` = 0 and `req_ready` = 4'b0000 while `fifo_full` = 1. After one FIFO read, exactly one write occurs from the pending owner with no data loss; read-back matches the model.
- **Reset mid-burst:** assert `rst` during beat 2 of requester 1. Expected: no write that cycle, then `state` = IDLE, `rr_ptr` = 0, and requester 0 wins first after reset.
- **Sparse requests:** only requester 3 is valid with `rr_ptr` = 0. Expected: it wins immediately, and `rr_ptr` becomes 0 after the transfer (wrap).
